// File: rtl/arm_pkg.sv
// Shared ARM datapath definitions: condition-field encodings and NZCV/FlagW bit positions.
package arm_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit ARM condition field against the stored NZCV flags.
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n_s, z_s, c_s, v_s;

  assign n_s = flags[N_IDX];
  assign z_s = flags[Z_IDX];
  assign c_s = flags[C_IDX];
  assign v_s = flags[V_IDX];

  // Condition decode; NV and any unknown encoding resolve to "not executed".
  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(cond))
      EQ:      cond_ex = z_s;
      NE:      cond_ex = ~z_s;
      CS:      cond_ex = c_s;
      CC:      cond_ex = ~c_s;
      MI:      cond_ex = n_s;
      PL:      cond_ex = ~n_s;
      VS:      cond_ex = v_s;
      VC:      cond_ex = ~v_s;
      HI:      cond_ex = c_s & ~z_s;
      LS:      cond_ex = ~c_s | z_s;
      GE:      cond_ex = (n_s == v_s);
      LT:      cond_ex = (n_s != v_s);
      GT:      cond_ex = ~z_s & (n_s == v_s);
      LE:      cond_ex = z_s | (n_s != v_s);
      AL:      cond_ex = 1'b1;
      NV:      cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_reg.sv
// Resettable enable register holding one independently writable flag field.
module flag_reg #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Field storage: reset has priority over any write.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= {W{1'b0}};
    end else if (en) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/cond_logic.sv
// ARM conditional-execution unit: NZCV flag register, condition check and gating
// of the decoder's PC/register/memory write requests.
module cond_logic
  import arm_pkg::*;
#(
  parameter int NFLAGS = 4,
  parameter int COND_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [COND_W-1:0] Cond,
  input  logic [NFLAGS-1:0] ALUFlags,
  input  logic [1:0]        FlagW,
  input  logic              PCS,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              NoWrite,
  output logic              PCSrc,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              CondEx,
  output logic [NFLAGS-1:0] Flags
);

  logic [1:0] nz_r;
  logic [1:0] cv_r;
  logic       cond_pass_s;
  logic       cond_ex_s;
  logic       wr_nz_s;
  logic       wr_cv_s;

  // The check always sees the registered flags, so an instruction's own
  // flag update only becomes visible to the next one.
  assign Flags = {nz_r, cv_r};

  cond_check u_cond_check (
    .cond    (Cond),
    .flags   (Flags),
    .cond_ex (cond_pass_s)
  );

  assign cond_ex_s = cond_pass_s & ~reset;
  assign wr_nz_s   = FlagW[FLAGW_NZ] & cond_ex_s & en;
  assign wr_cv_s   = FlagW[FLAGW_CV] & cond_ex_s & en;

  flag_reg #(.W(2)) u_nz_reg (
    .clk   (clk),
    .reset (reset),
    .en    (wr_nz_s),
    .d     (ALUFlags[N_IDX:Z_IDX]),
    .q     (nz_r)
  );

  flag_reg #(.W(2)) u_cv_reg (
    .clk   (clk),
    .reset (reset),
    .en    (wr_cv_s),
    .d     (ALUFlags[C_IDX:V_IDX]),
    .q     (cv_r)
  );

  // Write-enable gating; stalls do not mask these, the datapath holds its own state.
  always_comb begin
    CondEx   = 1'b0;
    PCSrc    = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    if (cond_ex_s) begin
      CondEx   = 1'b1;
      PCSrc    = PCS;
      RegWrite = RegW & ~NoWrite;
      MemWrite = MemW;
    end else begin
      CondEx   = 1'b0;
      PCSrc    = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

endmodule
